rsa_host_ctrl: RTL and testbench

Bus initiator for the 256-bit modular-power register block. It accepts a byte stream of three 256-bit operands, writes them into the block's operand registers a1/a2/a3 over the byte-wide active-low bus, and issues start. It then waits for the compute handshake to complete, reads back the 32-byte result a0, and emits it as a byte stream. It sits between a host byte link (UART/FIFO side) and the register block.

---
 rtl/rsa_host_pkg.sv | 33 +++
 rtl/rsa_host_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_rsa_host_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_host_pkg.sv
// rsa_host_pkg
//   Shared types and constants for the modular-power host controller.
//   - state_t          : controller FSM states
//   - REG_A0..REG_A3   : register-select codes of the register block
//   - OPERAND_BYTES    : bytes per 256-bit operand / result
//   - LOAD_BYTES       : bytes streamed in per operation (a1, a2, a3)
//   - write_sel()      : register select for a given load byte index
package rsa_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_READ    = 3'd5,
        ST_SEND    = 3'd6
    } state_t;

    localparam logic [1:0] REG_A0 = 2'b00;
    localparam logic [1:0] REG_A1 = 2'b01;
    localparam logic [1:0] REG_A2 = 2'b10;
    localparam logic [1:0] REG_A3 = 2'b11;

    localparam int OPERAND_BYTES = 32;
    localparam int LOAD_BYTES    = 96;

    // Bytes 0..31 go to a1, 32..63 to a2, 64..95 to a3.
    function automatic logic [1:0] write_sel(input logic [6:0] idx);
        return REG_A1 + idx[6:5];
    endfunction

endpackage

// File: rtl/rsa_host_ctrl.sv
// rsa_host_ctrl
//   Bus initiator for the 256-bit modular-power register block. Streams
//   96 operand bytes (a1, a2, a3, each LSB first) into the block, pulses
//   start, waits for the busy flag to rise and fall, then reads the 32-byte
//   result a0 and streams it out LSB first.
//
//   Optional feature macro: RSA_HOST_TIMEOUT_EN
//     defined   : each compute-wait state gives up after TIMEOUT_CYCLES,
//                 sets the sticky err output and returns to IDLE.
//     undefined : no err port, the wait states wait forever.
//
//   Ports
//     clk, reset            clock (rising edge), async active-low reset
//     in_valid/in_ready/in_data     host byte input
//     out_valid/out_ready/out_data  result byte output
//     bus_we_n, bus_oe_n, bus_start_n  active-low register-block strobes
//     bus_reg_sel, bus_addr, bus_wdata register select, byte index, data
//     bus_rdata             combinational read data from the block
//     bus_ready             block busy flag (1 while computing)
//     busy                  high whenever the FSM is not in IDLE
//     dbg_state             current FSM state (state_t encoding)
//     err                   sticky timeout flag (timeout build only)
//
//   Handshake: a byte moves on a rising edge where valid & ready are both
//   high. The source holds valid and data stable until that edge; ready may
//   change freely and never depends combinationally on valid.
module rsa_host_ctrl
    import rsa_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       bus_we_n,
    output logic       bus_oe_n,
    output logic       bus_start_n,
    output logic [1:0] bus_reg_sel,
    output logic [4:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       bus_ready,
    output logic       busy,
    output logic [2:0] dbg_state
`ifdef RSA_HOST_TIMEOUT_EN
    ,
    output logic       err
`endif
);

    localparam logic [6:0] LAST_IDX = 7'(LOAD_BYTES - 1);
    localparam logic [4:0] LAST_K   = 5'(OPERAND_BYTES - 1);

    // The wait counter needs at least one bit.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("rsa_host_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

`ifdef RSA_HOST_TIMEOUT_EN
    localparam int            WAIT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    logic [WAIT_W-1:0] wait_cnt;
`endif

    state_t     state;
    logic [6:0] idx;   // next load byte index
    logic [4:0] k;     // result byte index being read/sent

    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            idx         <= 7'd0;
            k           <= 5'd0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
            bus_we_n    <= 1'b1;
            bus_oe_n    <= 1'b1;
            bus_start_n <= 1'b1;
            bus_reg_sel <= REG_A0;
            bus_addr    <= 5'd0;
            bus_wdata   <= 8'h00;
            busy        <= 1'b0;
`ifdef RSA_HOST_TIMEOUT_EN
            wait_cnt    <= '0;
            err         <= 1'b0;
`endif
        end else begin
            // Write and start strobes are single-cycle unless re-armed below.
            bus_we_n    <= 1'b1;
            bus_start_n <= 1'b1;

            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        // First byte is idx 0: write a1[0] next cycle.
                        bus_we_n    <= 1'b0;
                        bus_reg_sel <= write_sel(7'd0);
                        bus_addr    <= 5'd0;
                        bus_wdata   <= in_data;
                        idx         <= 7'd1;
                        busy        <= 1'b1;
                        state       <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        bus_we_n    <= 1'b0;
                        bus_reg_sel <= write_sel(idx);
                        bus_addr    <= idx[4:0];
                        bus_wdata   <= in_data;
                        if (idx == LAST_IDX) begin
                            in_ready <= 1'b0;
                            idx      <= 7'd0;
                            state    <= ST_START;
                        end else begin
                            idx <= idx + 7'd1;
                        end
                    end
                end

                // The first START cycle carries the last write strobe; the
                // start pulse follows on the next cycle with we_n high.
                ST_START: begin
                    bus_start_n <= 1'b0;
                    bus_reg_sel <= REG_A0;
                    bus_addr    <= 5'd0;
                    state       <= ST_WAIT_HI;
`ifdef RSA_HOST_TIMEOUT_EN
                    wait_cnt    <= '0;
`endif
                end

                ST_WAIT_HI: begin
                    if (bus_ready) begin
                        state <= ST_WAIT_LO;
`ifdef RSA_HOST_TIMEOUT_EN
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end

                ST_WAIT_LO: begin
                    if (!bus_ready) begin
                        // a0 is valid now: set up the read of byte 0.
                        k           <= 5'd0;
                        bus_oe_n    <= 1'b0;
                        bus_reg_sel <= REG_A0;
                        bus_addr    <= 5'd0;
                        state       <= ST_READ;
`ifdef RSA_HOST_TIMEOUT_EN
                    end else if (wait_cnt == WAIT_LAST) begin
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end

                ST_READ: begin
                    bus_oe_n  <= 1'b1;
                    out_data  <= bus_rdata;
                    out_valid <= 1'b1;
                    state     <= ST_SEND;
                end

                ST_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (k == LAST_K) begin
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            k        <= k + 5'd1;
                            bus_oe_n <= 1'b0;
                            bus_addr <= k + 5'd1;
                            state    <= ST_READ;
                        end
                    end
                end

                default: begin
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_host_ctrl.sv
// tb_rsa_host_ctrl
//   Directed bench for rsa_host_ctrl with a behavioural register block.
//   Expected bus writes are queued as input bytes are accepted, expected
//   result bytes are queued when the block model computes a0; monitors pop
//   and compare as the DUT produces strobes and output bytes.
module tb_rsa_host_ctrl;
    import rsa_host_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       bus_we_n, bus_oe_n, bus_start_n;
    logic [1:0] bus_reg_sel;
    logic [4:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_ready;
    logic       busy;
    logic [2:0] dbg_state;
`ifdef RSA_HOST_TIMEOUT_EN
    logic       err;
`endif

    rsa_host_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .bus_we_n(bus_we_n), .bus_oe_n(bus_oe_n), .bus_start_n(bus_start_n),
        .bus_reg_sel(bus_reg_sel), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .busy(busy), .dbg_state(dbg_state)
`ifdef RSA_HOST_TIMEOUT_EN
        , .err(err)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- register block model ----------------
    logic [7:0] a0_mem [32];
    int         a0_mode = 0;      // 0: a0 = 0x0102..20, 1: random
    bit         ignore_start = 0;
    int         busy_left = 0;
    logic [7:0] exp_out_q [$];

    initial bus_ready = 1'b0;
    assign bus_rdata = bus_oe_n ? 8'h00 : a0_mem[bus_addr];

    always @(posedge clk) begin
        if (reset && !bus_start_n && !ignore_start) begin
            for (int i = 0; i < 32; i++) begin
                a0_mem[i] = (a0_mode == 0) ? 8'(32 - i) : 8'($urandom_range(0, 255));
                exp_out_q.push_back(a0_mem[i]);
            end
            busy_left = 10;
        end
        #1;
        if (!reset) begin
            busy_left = 0;
            bus_ready = 1'b0;
        end else if (busy_left > 0) begin
            bus_ready = 1'b1;
            busy_left--;
        end else begin
            bus_ready = 1'b0;
        end
    end

    // ---------------- out_ready driver ----------------
    int ready_mode = 0;           // 0: held high, 1: toggle every 3 cycles
    int tog_cnt = 0;
    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            out_ready = 1'b1;
        end else begin
            tog_cnt++;
            if (tog_cnt == 3) begin
                out_ready = ~out_ready;
                tog_cnt = 0;
            end
        end
    end

    // ---------------- scoreboard / monitors ----------------
    logic [14:0] exp_wr_q [$];    // {sel, addr, wdata}
    logic [14:0] wr_log [$];
    int   ncyc = 0;
    int   exp_idx = 0;
    int   last_hs = 0;
    int   wr_count = 0, start_count = 0, out_count = 0, out_seen = 0;
    int   start_ncyc = 0, fall_ncyc = 0, err_ncyc = 0;
    logic [4:0] rd_k = 5'd0;
    bit   prev_br = 0, first_pending = 0, hold_pending = 0, busy_chk = 0, err_seen = 0;
    logic [7:0] held_data = 8'h00;

    always @(negedge clk) begin
        ncyc++;
        if (!reset) begin
            exp_idx = 0;
            exp_wr_q.delete();
            rd_k = 5'd0;
            prev_br = 0;
            first_pending = 0;
            hold_pending = 0;
            busy_chk = 0;
        end else begin
            if (busy_chk) begin
                check("busy_after_last", {31'd0, busy}, 32'd0);
                busy_chk = 0;
            end
            if (!bus_we_n) begin
                wr_count++;
                wr_log.push_back({bus_reg_sel, bus_addr, bus_wdata});
                if (exp_wr_q.size() == 0) check("write_unexpected", 32'd1, 32'd0);
                else check("write", {17'd0, bus_reg_sel, bus_addr, bus_wdata}, {17'd0, exp_wr_q.pop_front()});
                check("write_while_busy", {31'd0, bus_ready}, 32'd0);
            end
            if (in_valid && in_ready) begin
                exp_wr_q.push_back({2'(1 + exp_idx / 32), 5'(exp_idx % 32), in_data});
                last_hs = ncyc;
                exp_idx = (exp_idx == 95) ? 0 : exp_idx + 1;
            end
            if (!bus_start_n) begin
                start_count++;
                start_ncyc = ncyc;
                check("start_latency", 32'(ncyc - last_hs), 32'd2);
                check("start_strobes", {30'd0, bus_we_n, bus_oe_n}, 32'd3);
            end
            if (!bus_oe_n) begin
                check("read_addr", {25'd0, bus_reg_sel, bus_addr}, {25'd0, REG_A0, rd_k});
                rd_k = rd_k + 5'd1;
            end
            if (prev_br && !bus_ready) begin
                fall_ncyc = ncyc;
                first_pending = 1;
            end
            prev_br = bus_ready;
            if (out_valid) out_seen++;
            if (out_valid && first_pending) begin
                check("first_byte_latency", 32'(ncyc - fall_ncyc), 32'd2);
                first_pending = 0;
            end
            if (hold_pending)
                check("out_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, held_data});
            hold_pending = out_valid && !out_ready;
            held_data = out_data;
            if (out_valid && out_ready) begin
                out_count++;
                if (exp_out_q.size() == 0) check("out_unexpected", 32'd1, 32'd0);
                else check("out_byte", {24'd0, out_data}, {24'd0, exp_out_q.pop_front()});
                if (out_count % 32 == 0) busy_chk = 1;
            end
`ifdef RSA_HOST_TIMEOUT_EN
            if (err && !err_seen) begin
                err_seen = 1;
                err_ncyc = ncyc;
            end
`endif
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the byte is accepted.
    task automatic send_byte(input logic [7:0] d);
        int  n;
        bit  hs;
        n = 0;
        hs = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = in_ready;
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!hs) check("in_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic load_stream(input bit pattern, input int nbytes, input int gap_max);
        logic [7:0] d;
        for (int i = 0; i < nbytes; i++) begin
            d = pattern ? 8'(i) : 8'($urandom_range(0, 255));
            send_byte(d);
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_outputs(input int target);
        int n;
        n = 0;
        while (out_count < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("out_wait_timeout", {31'd0, out_count >= target}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready}, 32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_data"},  {24'd0, out_data}, 32'd0);
        check({tag, "_strobes"},   {29'd0, bus_we_n, bus_oe_n, bus_start_n}, 32'd7);
        check({tag, "_sel_addr"},  {25'd0, bus_reg_sel, bus_addr}, 32'd0);
        check({tag, "_wdata"},     {24'd0, bus_wdata}, 32'd0);
        check({tag, "_busy"},      {31'd0, busy}, 32'd0);
        check({tag, "_state"},     {29'd0, dbg_state}, {29'd0, ST_IDLE});
`ifdef RSA_HOST_TIMEOUT_EN
        check({tag, "_err"},       {31'd0, err}, 32'd0);
`endif
    endtask

    // ---------------- directed sequence ----------------
    int wr_base, st_base, out_base, seen_base;

    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_initial");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of LOAD, after idx 0..39 were accepted.
        load_stream(0, 40, 0);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid_load");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Back-to-back 0x00..0x5F, fixed a0, out_ready held high.
        wr_base = wr_count; st_base = start_count; out_base = out_count;
        a0_mode = 0; ready_mode = 0;
        load_stream(1, 96, 0);
        wait_outputs(out_base + 32);
        check("p1_writes", 32'(wr_count - wr_base), 32'd96);
        check("p1_starts", 32'(start_count - st_base), 32'd1);
        check("p1_outs", 32'(out_count - out_base), 32'd32);
        check("p1_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        check("p1_out_q_empty", 32'(exp_out_q.size()), 32'd0);
        check("p1_wr33", {17'd0, wr_log[wr_base + 33]}, {17'd0, 2'b10, 5'd1, 8'h21});
        check("p1_wr95", {25'd0, wr_log[wr_base + 95][14:8]}, {25'd0, 2'b11, 5'd31});
        check("p1_idle_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("p1_in_ready", {31'd0, in_ready}, 32'd1);

        // Random data with input gaps, random a0, out_ready toggling.
        wr_base = wr_count; st_base = start_count; out_base = out_count;
        a0_mode = 1; ready_mode = 1;
        load_stream(0, 96, 4);
        wait_outputs(out_base + 32);
        check("p2_writes", 32'(wr_count - wr_base), 32'd96);
        check("p2_starts", 32'(start_count - st_base), 32'd1);
        check("p2_outs", 32'(out_count - out_base), 32'd32);
        check("p2_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        check("p2_out_q_empty", 32'(exp_out_q.size()), 32'd0);
        check("p2_busy", {31'd0, busy}, 32'd0);
        ready_mode = 0;

`ifdef RSA_HOST_TIMEOUT_EN
        // Block ignores start: only the wait timeout recovers.
        begin
            int n;
            ignore_start = 1;
            seen_base = out_seen;
            load_stream(1, 96, 0);
            n = 0;
            while (!err_seen && n < 300) begin
                @(posedge clk);
                n++;
            end
            repeat (3) @(posedge clk);
            #1;
            check("to_err_set", {31'd0, err_seen}, 32'd1);
            check("to_latency", 32'(err_ncyc - start_ncyc), 32'd16);
            check("to_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
            check("to_busy", {31'd0, busy}, 32'd0);
            check("to_no_out", 32'(out_seen - seen_base), 32'd0);
            check("to_err_sticky", {31'd0, err}, 32'd1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
